// File: rtl/cycle_mode_controller_if.sv
// Front-panel signal bundle between the push-buttons and the display/datapath.
// The master drives the raw buttons; the slave (the controller) drives the display controls.
interface cycle_mode_controller_if;
   logic       nMode;
   logic       nTrip;
   logic [1:0] mode_sel;
   logic       units_mi;
   logic       trip_clear;
   logic       display_update;

   modport master (
      output nMode, nTrip,
      input  mode_sel, units_mi, trip_clear, display_update
   );

   modport slave (
      input  nMode, nTrip,
      output mode_sel, units_mi, trip_clear, display_update
   );
endinterface

// File: rtl/cycle_mode_controller.sv
// Cycle computer front panel: button sync/debounce, short/long press FSMs, mode/units/trip actions
// and display refresh strobe. Define AUTO_SCROLL_EN to build the idle auto-scroll of mode_sel.
module cycle_mode_controller #(
   parameter int unsigned DEBOUNCE_CYCLES     = 16,
   parameter int unsigned LONG_PRESS_CYCLES   = 320,
`ifdef AUTO_SCROLL_EN
   parameter int unsigned AUTO_SCROLL_UPDATES = 5,
`endif
   parameter int unsigned UPDATE_PERIOD       = 1000
) (
   input logic                    HCLK,
   input logic                    HRESETn,
   cycle_mode_controller_if.slave bus
);
   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam int unsigned TmrW  = $clog2(UPDATE_PERIOD);
   localparam int          BtnMode = 0;
   localparam int          BtnTrip = 1;

   typedef enum logic [1:0] {StIdle, StHeld, StLong} press_st_e;

   logic [1:0]       raw;
   logic [1:0]       sync1_q, sync2_q, deb_q, deb_d;
   logic [DbW-1:0]   db_cnt_q [2];
   logic [DbW-1:0]   db_cnt_d [2];
   press_st_e        st_q [2];
   press_st_e        st_d [2];
   logic [HoldW-1:0] hold_q [2];
   logic [HoldW-1:0] hold_d [2];
   logic [1:0]       short_ev, long_ev;
   logic             mode_inc, mode_dec, auto_step;
   logic [1:0]       mode_sel_q, mode_sel_d;
   logic             units_q, units_d, clear_q, clear_d, action_q, action_d;
   logic [TmrW-1:0]  timer_q, timer_d;
   logic             update_q, update_d, wrap;

   assign raw = {bus.nTrip, bus.nMode};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         deb_q   <= 2'b11;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
            else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   // Press FSMs: state register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]   <= StIdle;
            hold_q[i] <= '0;
         end
      end else begin
         st_q   <= st_d;
         hold_q <= hold_d;
      end
   end

   // hold counts debounced-low cycles including the current one, so Held starts at 2
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i]   = st_q[i];
         hold_d[i] = hold_q[i];
         case (st_q[i])
            StIdle: begin
               hold_d[i] = '0;
               if (!deb_q[i]) begin
                  st_d[i]   = StHeld;
                  hold_d[i] = HoldW'(2);
               end
            end
            StHeld: begin
               if (hold_q[i] == HoldW'(LONG_PRESS_CYCLES)) begin
                  st_d[i] = StLong;
               end else if (deb_q[i]) begin
                  st_d[i]   = StIdle;
                  hold_d[i] = '0;
               end else begin
                  hold_d[i] = hold_q[i] + 1'b1;
               end
            end
            StLong: begin
               if (deb_q[i]) begin
                  st_d[i]   = StIdle;
                  hold_d[i] = '0;
               end
            end
            default: st_d[i] = StIdle;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         long_ev[i]  = (st_q[i] == StHeld) && (hold_q[i] == HoldW'(LONG_PRESS_CYCLES));
         short_ev[i] = (st_q[i] == StHeld) && deb_q[i] && !long_ev[i];
      end
   end

`ifdef AUTO_SCROLL_EN
   localparam int unsigned IdleW = $clog2(AUTO_SCROLL_UPDATES + 1);
   logic [IdleW-1:0] idle_q, idle_d;
   logic             press_start, all_idle;

   assign all_idle    = (st_q[BtnMode] == StIdle) && (st_q[BtnTrip] == StIdle);
   assign press_start = all_idle && (deb_q != 2'b11);

   always_comb begin
      idle_d    = idle_q;
      auto_step = 1'b0;
      if (press_start) begin
         idle_d = '0;
      end else if (update_q && all_idle) begin
         if (idle_q == IdleW'(AUTO_SCROLL_UPDATES - 1)) begin
            idle_d    = '0;
            auto_step = 1'b1;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) idle_q <= '0;
      else          idle_q <= idle_d;
   end
`else
   assign auto_step = 1'b0;
`endif

   // Coincident short presses cancel each other
   assign mode_inc = (short_ev[BtnMode] && !short_ev[BtnTrip]) || auto_step;
   assign mode_dec = short_ev[BtnTrip] && !short_ev[BtnMode];
   assign wrap     = (timer_q == TmrW'(UPDATE_PERIOD - 1));

   always_comb begin
      mode_sel_d = mode_sel_q;
      if (mode_inc)      mode_sel_d = mode_sel_q + 2'd1;
      else if (mode_dec) mode_sel_d = mode_sel_q - 2'd1;
      units_d  = units_q ^ long_ev[BtnMode];
      clear_d  = long_ev[BtnTrip];
      action_d = mode_inc || mode_dec || long_ev[BtnMode] || long_ev[BtnTrip];
      timer_d  = (action_q || wrap) ? '0 : timer_q + 1'b1;
      update_d = (action_q || wrap) && !update_q;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         mode_sel_q <= 2'd0;
         units_q    <= 1'b0;
         clear_q    <= 1'b0;
         action_q   <= 1'b0;
         timer_q    <= '0;
         update_q   <= 1'b0;
      end else begin
         mode_sel_q <= mode_sel_d;
         units_q    <= units_d;
         clear_q    <= clear_d;
         action_q   <= action_d;
         timer_q    <= timer_d;
         update_q   <= update_d;
      end
   end

   assign bus.mode_sel       = mode_sel_q;
   assign bus.units_mi       = units_q;
   assign bus.trip_clear     = clear_q;
   assign bus.display_update = update_q;
endmodule

// File: tb/tb_cycle_mode_controller.sv
// Scoreboard bench for cycle_mode_controller: stimulus pushes expected actions, a negedge
// monitor pops them as the outputs change and checks display_update pulse timing.
module tb_cycle_mode_controller;
   localparam int Period   = 1000;
   // release -> 18 cycles debounce -> short event -> registered action
   localparam int ShortLat = 19;
   // press -> 18 cycles debounce -> 320 held cycles -> registered action
   localparam int LongLat  = 338;

   typedef struct {
      int         cyc;
      logic [1:0] mode;
      logic       units;
      logic       clear;
   } act_t;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   act_t act_q[$];
   int   upd_q[$];

   cycle_mode_controller_if bus_if ();

   cycle_mode_controller dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus_if)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic hold_buttons(input bit m, input bit t, input int len);
      if (m) bus_if.nMode = 1'b0;
      if (t) bus_if.nTrip = 1'b0;
      tick(len);
      bus_if.nMode = 1'b1;
      bus_if.nTrip = 1'b1;
   endtask

   task automatic expect_act(input int c, input logic [1:0] m, input logic u, input logic cl);
      act_t e;
      e.cyc   = c;
      e.mode  = m;
      e.units = u;
      e.clear = cl;
      act_q.push_back(e);
   endtask

   // Monitor: action events and display_update pulses
   logic [1:0] prev_mode;
   logic       prev_units;
   int         restart;
   bit         prev_exp, forced, periodic, exp_upd;
   act_t       got;

   initial begin
      prev_mode  = 2'd0;
      prev_units = 1'b0;
      restart    = 0;
      prev_exp   = 1'b0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            prev_mode  = 2'd0;
            prev_units = 1'b0;
            restart    = cyc;
            prev_exp   = 1'b0;
            upd_q.delete();
         end else begin
            if (bus_if.mode_sel !== prev_mode || bus_if.units_mi !== prev_units ||
                bus_if.trip_clear !== 1'b0) begin
               n_checks++;
               if (act_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_action: cycle %0d mode_sel=%0d units_mi=%0b trip_clear=%0b, required no change",
                           cyc, bus_if.mode_sel, bus_if.units_mi, bus_if.trip_clear);
               end else begin
                  got = act_q.pop_front();
                  if (got.cyc != cyc || got.mode !== bus_if.mode_sel ||
                      got.units !== bus_if.units_mi || got.clear !== bus_if.trip_clear) begin
                     n_fail++;
                     $display("FAIL action: got cycle %0d mode_sel=%0d units_mi=%0b trip_clear=%0b, required cycle %0d mode_sel=%0d units_mi=%0b trip_clear=%0b",
                              cyc, bus_if.mode_sel, bus_if.units_mi, bus_if.trip_clear,
                              got.cyc, got.mode, got.units, got.clear);
                  end
                  upd_q.push_back(got.cyc + 1);
               end
               prev_mode  = bus_if.mode_sel;
               prev_units = bus_if.units_mi;
            end
            while (upd_q.size() > 0 && upd_q[0] < cyc) void'(upd_q.pop_front());
            forced = (upd_q.size() > 0 && upd_q[0] == cyc);
            if (forced) void'(upd_q.pop_front());
            periodic = (cyc == restart + Period);
            exp_upd  = (forced || periodic) && !prev_exp;
            if (forced || periodic) restart = cyc;
            if (exp_upd || bus_if.display_update !== 1'b0) begin
               n_checks++;
               if (bus_if.display_update !== exp_upd) begin
                  n_fail++;
                  $display("FAIL display_update: cycle %0d got %0b, required %0b",
                           cyc, bus_if.display_update, exp_upd);
               end
            end
            prev_exp = exp_upd;
         end
      end
   end

   logic [1:0] step_modes [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      bus_if.nMode = 1'b1;
      bus_if.nTrip = 1'b1;
      HRESETn      = 1'b0;
      repeat (3) @(negedge HCLK);
      check("rst_mode_sel", int'(bus_if.mode_sel), 0);
      check("rst_units_mi", int'(bus_if.units_mi), 0);
      check("rst_trip_clear", int'(bus_if.trip_clear), 0);
      check("rst_display_update", int'(bus_if.display_update), 0);
      #1 HRESETn = 1'b1;
      tick(1100);

      // Four short mode presses walk 0->1->2->3->0
      for (int i = 0; i < 4; i++) begin
         hold_buttons(1'b1, 1'b0, 100);
         expect_act(cyc + ShortLat, step_modes[i], 1'b0, 1'b0);
         tick(60);
      end

      // Contact bounce then a 10-cycle glitch: nothing may happen
      for (int k = 0; k < 12; k++) begin
         bus_if.nMode = k[0];
         tick(5);
      end
      bus_if.nMode = 1'b1;
      tick(40);
      hold_buttons(1'b1, 1'b0, 10);
      tick(60);

      // Long trip press clears the trip; long mode press toggles units
      expect_act(cyc + LongLat, 2'd0, 1'b0, 1'b1);
      hold_buttons(1'b0, 1'b1, 400);
      tick(60);
      expect_act(cyc + LongLat, 2'd0, 1'b1, 1'b0);
      hold_buttons(1'b1, 1'b0, 400);
      tick(60);

      // Simultaneous short presses cancel; trip short alone wraps 0->3
      hold_buttons(1'b1, 1'b1, 50);
      tick(60);
      hold_buttons(1'b0, 1'b1, 100);
      expect_act(cyc + ShortLat, 2'd3, 1'b1, 1'b0);
      tick(60);
      check("pending_before_reset", act_q.size(), 0);

      // Asynchronous reset mid-run clears outputs immediately
      #2 HRESETn = 1'b0;
      #1;
      check("midrst_mode_sel", int'(bus_if.mode_sel), 0);
      check("midrst_units_mi", int'(bus_if.units_mi), 0);
      check("midrst_trip_clear", int'(bus_if.trip_clear), 0);
      check("midrst_display_update", int'(bus_if.display_update), 0);
      @(negedge HCLK);
      #1 HRESETn = 1'b1;
      tick(1100);

      check("pending_at_end", act_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
